// File: rtl/odd_counter_pkg.sv
// Shared defaults and helpers for the odd-value sequence counter.
// The top level and the odd_step datapath both import this package.
package odd_counter_pkg;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_INIT_ODD = 1;

  // Largest odd value representable in 'width' bits.
  function automatic int max_odd(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/odd_step.sv
// Combinational next-value logic: advance by two, or substitute INIT_ODD after MAX_ODD.
module odd_step
  import odd_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int INIT_ODD = DEFAULT_INIT_ODD
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             is_wrap
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(max_odd(WIDTH));
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_ODD);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(2);

  logic [WIDTH-1:0] inc;

  // Adding at WIDTH bits is the same as a WIDTH+1-bit add with the carry dropped.
  assign inc     = cur + STEP_V;
  assign is_wrap = (cur == MAX_V);
  // The explicit compare matters whenever INIT_ODD is not 1.
  assign nxt     = is_wrap ? INIT_V : inc;

endmodule

// File: rtl/odd_counter.sv
// Free-running counter over odd values INIT_ODD..MAX_ODD with a registered wrap flag.
// Synchronous active-high reset; one clock.
module odd_counter
  import odd_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int INIT_ODD = DEFAULT_INIT_ODD
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  if (WIDTH < 2) begin : g_bad_width
    $error("odd_counter: WIDTH must be at least 2");
  end
  if ((INIT_ODD % 2) == 0) begin : g_even_init
    $error("odd_counter: INIT_ODD must be odd");
  end
  if (INIT_ODD >= (1 << WIDTH)) begin : g_init_range
    $error("odd_counter: INIT_ODD must be below 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_ODD);

  logic [WIDTH-1:0] nxt;
  logic             is_wrap;

  odd_step #(
    .WIDTH    (WIDTH),
    .INIT_ODD (INIT_ODD)
  ) u_step (
    .cur     (count),
    .nxt     (nxt),
    .is_wrap (is_wrap)
  );

  // NOTE: non-blocking assignments so count and wrap both update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= INIT_V;
      wrap  <= 1'b0;
    end else begin
      count <= nxt;
      wrap  <= is_wrap;
    end
  end

  // NOTE: reset_seen is deliberately left without reset; it stays X until the first
  // reset edge, which keeps the parity check quiet before the counter is defined.
  logic reset_seen;
  always_ff @(posedge clk) begin
    reset_seen <= reset_seen | reset;
  end

  always_ff @(posedge clk) begin
    if (reset_seen && !reset) begin
      assert (count[0] === 1'b1)
        else $error("odd_counter: count %0d is even or unknown", count);
    end
  end

endmodule

// File: tb/tb_odd_counter.sv
// Scoreboard bench for odd_counter at default parameters (WIDTH=4, INIT_ODD=1).
// A reference model pushes expected count/wrap per edge; each test pops and compares.
module tb_odd_counter;

  typedef struct {
    logic [3:0] count;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       wrap;

  exp_t       sb[$];
  exp_t       got;
  logic [3:0] m_count;
  logic       m_wrap;
  int         checks;
  int         failures;

  odd_counter #(.WIDTH(4), .INIT_ODD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Drive one edge with reset=r, push the model's expected result, sample 1 unit after the edge.
  task automatic drive_edge(input logic r);
    exp_t e;
    reset = r;
    if (r) begin
      m_count = 4'd1;
      m_wrap  = 1'b0;
    end else if (m_count == 4'd15) begin
      m_count = 4'd1;
      m_wrap  = 1'b1;
    end else begin
      m_count = m_count + 4'd2;
      m_wrap  = 1'b0;
    end
    e.count = m_count;
    e.wrap  = m_wrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_edge(1'b1);
    got = sb.pop_front();
    checks++;
    if (count !== 4'd1 || wrap !== 1'b0 || count !== got.count) begin
      failures++;
      $display("FAIL reset: count=%0d wrap=%0b, required count=1 wrap=0", count, wrap);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] tbl_count [10];
    logic       tbl_wrap  [10];
    tbl_count = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1, 4'd3};
    tbl_wrap  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_edge(i == 0);
      got = sb.pop_front();
      checks++;
      if (count !== got.count || wrap !== got.wrap ||
          count !== tbl_count[i] || wrap !== tbl_wrap[i]) begin
        failures++;
        $display("FAIL sequence[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                 i, count, wrap, tbl_count[i], tbl_wrap[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    drive_edge(1'b1);
    void'(sb.pop_front());
    n = 0;
    while (count !== 4'd5 && n < 20) begin
      drive_edge(1'b0);
      got = sb.pop_front();
      checks++;
      if (count !== got.count || wrap !== got.wrap) begin
        failures++;
        $display("FAIL mid_run: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                 count, wrap, got.count, got.wrap);
      end
      n++;
    end
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL mid_reach5: count=%0d after %0d edges, required 5", count, n);
    end
    for (int i = 0; i < 3; i++) begin
      drive_edge(i == 0);
      got = sb.pop_front();
      checks++;
      if (count !== got.count || wrap !== got.wrap) begin
        failures++;
        $display("FAIL mid_reset[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                 i, count, wrap, got.count, got.wrap);
      end
    end
  endtask

  task automatic test_hold_reset();
    for (int i = 0; i < 5; i++) begin
      drive_edge(1'b1);
      got = sb.pop_front();
      checks++;
      if (count !== 4'd1 || wrap !== 1'b0 || count !== got.count) begin
        failures++;
        $display("FAIL hold_reset[%0d]: count=%0d wrap=%0b, required count=1 wrap=0",
                 i, count, wrap);
      end
    end
    drive_edge(1'b0);
    got = sb.pop_front();
    checks++;
    if (count !== 4'd3 || wrap !== 1'b0 || count !== got.count) begin
      failures++;
      $display("FAIL hold_release: count=%0d wrap=%0b, required count=3 wrap=0", count, wrap);
    end
  endtask

  task automatic test_reset_at_max();
    int n;
    drive_edge(1'b1);
    void'(sb.pop_front());
    n = 0;
    while (count !== 4'd15 && n < 20) begin
      drive_edge(1'b0);
      void'(sb.pop_front());
      n++;
    end
    checks++;
    if (count !== 4'd15) begin
      failures++;
      $display("FAIL max_reach15: count=%0d after %0d edges, required 15", count, n);
    end
    drive_edge(1'b1);
    got = sb.pop_front();
    checks++;
    if (count !== 4'd1 || wrap !== 1'b0 || wrap !== got.wrap) begin
      failures++;
      $display("FAIL reset_at_max: count=%0d wrap=%0b, required count=1 wrap=0", count, wrap);
    end
  endtask

  task automatic test_back_to_back();
    // Alternating reset/free edges: 1,3,1,3,... and wrap never set.
    for (int i = 0; i < 6; i++) begin
      drive_edge(i % 2 == 0);
      got = sb.pop_front();
      checks++;
      if (count !== got.count || wrap !== got.wrap) begin
        failures++;
        $display("FAIL back_to_back[%0d]: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                 i, count, wrap, got.count, got.wrap);
      end
    end
  endtask

  task automatic test_parity();
    drive_edge(1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive_edge(1'b0);
      got = sb.pop_front();
      checks++;
      if ($isunknown(count) || count[0] !== 1'b1 || count !== got.count) begin
        failures++;
        $display("FAIL parity[%0d]: count=%b, required odd value %0d", i, count, got.count);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m_count  = 4'd1;
    m_wrap   = 1'b0;
    test_reset();
    test_sequence();
    test_mid_reset();
    test_hold_reset();
    test_reset_at_max();
    test_back_to_back();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
